ula_controle_multiciclo: RTL
============================

// Module: ula_controle_multiciclo
// PURPOSE
//  Multicycle control FSM for the 8-bit NRISC processor. Sequences fetch/decode/execute/memory/writeback,
//  drives select and ula_op lines of the shared 8-bit ULA (add/sub/srl/sll/slt). ULA is reused for PC+1,
//  branch target and address calc; memory accessed over req/ack handshake with bounded wait.
// PARAMETERS
//  OPW       4   opcode width, opcode = instr[7:4]
//  WAIT_MAX  15  max cycles waiting for mem_ack before bus error (1..255)
// PORTS
//  clock        in   1  rising-edge clock
//  resetn       in   1  asynchronous active-low reset
//  instr        in   8  instruction register contents (opcode in [7:4])
//  zero         in   1  ULA zero flag (combinational from ULA)
//  mem_ack      in   1  memory done; sampled on rising edge
//  mem_req      out  1  memory request, held until ack
//  mem_we       out  1  1=write, valid with mem_req
//  addr_src     out  1  0=PC, 1=ALUOut
//  ir_write     out  1  load IR from memory data
//  pc_write     out  1  load PC
//  pc_src       out  2  00=ULA result, 01=ALUOut (branch target), 10=jump (instr[3:0])
//  ula_src_a    out  1  0=PC, 1=reg A
//  ula_src_b    out  2  00=reg B, 01=const 1, 10=sign-ext imm
//  ula_op       out  3  000 add, 001 sub, 010 srl, 011 sll, 100 slt
//  reg_write    out  1  register file write enable
//  reg_dst      out  1  0=R-type dest, 1=I-type dest
//  mem_to_reg   out  1  0=ALUOut, 1=memory data
//  halted       out  1  sticky; FSM in HALT
//  illegal      out  1  sticky; undefined opcode decoded
//  bus_err      out  1  sticky; mem_ack timeout
//  state_dbg    out  4  current state encoding
// BEHAVIOUR
//  Opcodes: 0 add,1 sub,2 srl,3 sll,4 slt (R); 5 addi,6 subi,7 slti (I); 8 lw,9 sw,A beq,B bne,C j,F halt;
//   D,E illegal.
//  Outputs Moore-decoded from state (plus mem_ack/zero where noted); unlisted outputs 0 in every state.
//  resetn low (async): state=IDLE(0), all outputs 0, wait counter 0, sticky flags cleared.
//  IDLE: all 0 -> FETCH next edge (first fetch 1 cycle after reset release).
//  FETCH: mem_req=1, addr_src=0; stay while !mem_ack. In ack cycle also ir_write=1, pc_write=1, pc_src=00,
//   ula_src_a=0, ula_src_b=01, ula_op=000 (PC+1) -> DECODE.
//  DECODE: ula_src_a=0, ula_src_b=10, ula_op=000 (branch target -> ALUOut). Next: 0-4 EXEC_R, 5-7 EXEC_I,
//   8/9 MEM_ADDR, A/B BRANCH, C JUMP, F HALT, D/E HALT with illegal=1.
//  EXEC_R: ula_src_a=1, ula_src_b=00, ula_op=opcode[2:0] -> WB_ALU. EXEC_I: ula_src_b=10,
//   ula_op=000/001/100 for addi/subi/slti -> WB_ALU.
//  WB_ALU: reg_write=1, mem_to_reg=0, reg_dst=(I-type) -> FETCH.
//  MEM_ADDR: ula_src_a=1, ula_src_b=10, ula_op=000 -> MEM_READ (lw) / MEM_WRITE (sw).
//  MEM_READ: mem_req=1, addr_src=1; wait ack -> WB_MEM. WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=1 -> FETCH.
//  MEM_WRITE: mem_req=1, mem_we=1, addr_src=1; wait ack -> FETCH.
//  BRANCH: ula_src_a=1, ula_src_b=00, ula_op=001; pc_src=01; pc_write=(beq&zero)|(bne&!zero) -> FETCH.
//  JUMP: pc_write=1, pc_src=10 -> FETCH.
//  HALT: halted=1; absorbing until resetn.
//  Wait counter: clears on entering any mem state, increments each cycle without ack; ack on cycle
//   WAIT_MAX still accepted; no ack after WAIT_MAX waits -> HALT, bus_err=1, mem_req drops.
//  mem_req/mem_we/addr_src stable while waiting; ack outside mem states ignored.
//  Latency: R/I 4 cycles, lw 5, sw 4, beq/bne/j 3 (zero-wait memory).
//  resetn asserted mid-instruction: immediate IDLE, no further writes.
// TESTING
//  add, ack same cycle: FETCH->DECODE->EXEC_R(ula_op=000)->WB_ALU(reg_write=1,reg_dst=0)->FETCH, 4 cycles.
//  beq zero=1 -> pc_write=1,pc_src=01 in BRANCH; zero=0 -> pc_write=0; bne inverse.
//  lw, ack delayed 3 cycles in MEM_READ -> mem_req/addr_src=1 held 4 cycles, then WB_MEM mem_to_reg=1.
//  sw, mem_ack never -> after 15 wait cycles HALT, bus_err=1, halted=1, mem_req=0; stays until reset.
//  Opcode D -> HALT, illegal=1; opcode F -> HALT, illegal=0; both hold through 20 clocks.
//  resetn low during WB_ALU -> outputs 0 async, state_dbg=0; after release FETCH 1 cycle later.

Source files
------------

// File: rtl/ula_controle_multiciclo.sv
// ---------------------------------------------------------------------------
// ula_controle_multiciclo
//   Multicycle control FSM for the 8-bit NRISC processor. It sequences
//   fetch / decode / execute / memory / writeback. It also steers the single
//   shared ULA, which is reused for PC+1, the branch target and the address
//   calculation. Memory is reached over a req/ack handshake with a bounded
//   wait.
//
// Handshake: mem_req (with mem_we/addr_src) rises on entry to a memory state.
//   These lines are held steady until mem_ack is sampled high on a rising
//   edge. The edge that samples mem_ack completes the transfer.
//   When mem_ack has not arrived after WAIT_MAX waiting cycles, the FSM parks
//   in HALT with bus_err set. mem_ack is ignored outside memory states.
//
// Ports
//   clock, resetn   rising-edge clock, asynchronous active-low reset
//   instr[7:0]      instruction register (opcode = instr[7:4])
//   zero            ULA zero flag
//   mem_ack         memory done
//   mem_req/mem_we/addr_src          memory request controls
//   ir_write/pc_write/pc_src         IR / PC load controls
//   ula_src_a/ula_src_b/ula_op       shared ULA operand and operation select
//   reg_write/reg_dst/mem_to_reg     register file write controls
//   halted/illegal/bus_err           sticky status
//   state_dbg[3:0]                   current state encoding
// ---------------------------------------------------------------------------
module ula_controle_multiciclo #(
  parameter int OPW      = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] instr,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ula_src_a,
  output logic [1:0] ula_src_b,
  output logic [2:0] ula_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       halted,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_WB_ALU    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_WB_MEM    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
  localparam logic [OPW-1:0] OP_SUBI = OPW'(6);
  localparam logic [OPW-1:0] OP_SLTI = OPW'(7);
  localparam logic [OPW-1:0] OP_LW   = OPW'(8);
  localparam logic [OPW-1:0] OP_SW   = OPW'(9);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(10);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(11);
  localparam logic [OPW-1:0] OP_J    = OPW'(12);
  localparam logic [OPW-1:0] OP_HALT = OPW'(15);
  localparam logic [7:0]     WAIT_LIM = 8'(WAIT_MAX);

  state_t         state_q, state_d;
  logic [7:0]     wait_q, wait_d;
  logic           illegal_q, illegal_d;
  logic           bus_err_q, bus_err_d;
  logic [OPW-1:0] opcode;
  logic           is_itype;
  logic           in_mem;
  logic           timeout;

  assign opcode   = instr[7 -: OPW];
  assign is_itype = (opcode == OP_ADDI) || (opcode == OP_SUBI) || (opcode == OP_SLTI);
  assign in_mem   = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  // The last accepted ack arrives with wait_q == WAIT_MAX; no ack then is the timeout.
  assign timeout  = in_mem && !mem_ack && (wait_q == WAIT_LIM);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_src   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ula_src_a  = 1'b0;
    ula_src_b  = 2'b00;
    ula_op     = 3'b000;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          // PC+1 on the ULA, written to PC in the same cycle the IR loads.
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          ula_src_b = 2'b01;
          state_d   = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target is precomputed here into ALUOut.
        ula_src_b = 2'b10;
        if (opcode <= OPW'(4))                          state_d = S_EXEC_R;
        else if (is_itype)                              state_d = S_EXEC_I;
        else if (opcode == OP_LW || opcode == OP_SW)    state_d = S_MEM_ADDR;
        else if (opcode == OP_BEQ || opcode == OP_BNE)  state_d = S_BRANCH;
        else if (opcode == OP_J)                        state_d = S_JUMP;
        else if (opcode == OP_HALT)                     state_d = S_HALT;
        else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end

      S_EXEC_R: begin
        ula_src_a = 1'b1;
        ula_op    = opcode[2:0];
        state_d   = S_WB_ALU;
      end

      S_EXEC_I: begin
        ula_src_b = 2'b10;
        if (opcode == OP_SUBI)      ula_op = 3'b001;
        else if (opcode == OP_SLTI) ula_op = 3'b100;
        else                        ula_op = 3'b000;
        state_d = S_WB_ALU;
      end

      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = is_itype;
        state_d   = S_FETCH;
      end

      S_MEM_ADDR: begin
        ula_src_a = 1'b1;
        ula_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
        if (mem_ack) state_d = S_WB_MEM;
      end

      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        reg_dst    = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WRITE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_src = 1'b1;
        if (mem_ack) state_d = S_FETCH;
      end

      S_BRANCH: begin
        ula_src_a = 1'b1;
        ula_op    = 3'b001;
        pc_src    = 2'b01;
        pc_write  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      state_d   = S_HALT;
      bus_err_d = 1'b1;
    end
  end

  // Counts waiting cycles; restarts on every state change so each memory
  // state gets its own budget.
  always_comb begin
    wait_d = 8'd0;
    if (in_mem && (state_d == state_q)) wait_d = wait_q + 8'd1;
  end

  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;
  assign state_dbg = state_q;

endmodule
